uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
- Transmit-side UART stage sitting directly downstream of the TX byte FIFO.
- Pops one byte at a time from the FIFO's first-word-fall-through read port.
- Serializes each byte as an 8N1 frame: start bit, data LSB first, stop bit. Each bit lasts BAUD_DIV clocks.
- Drives the chip-level txd pin and reports busy status to the UART register block.

Parameters:
- DATA_WIDTH, 8, bits per character; legal range 5..8.
- BAUD_DIV, 434, clocks per bit (50 MHz / 115200); legal range 2 .. 2^DIV_WIDTH-1.
- DIV_WIDTH, 16, width of the baud counter.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  synchronous reset, active-high.
- enable_i  in  1  permits starting a new frame; a frame already in progress always completes.
- fifo_data_i  in  DATA_WIDTH  FIFO head word; valid whenever fifo_empty_i=0.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_ren_o  out  1  pop strobe to the FIFO; combinational, one cycle per character.
- txd_o  out  1  serial line output, registered; idles high.
- busy_o  out  1  high while any frame is in progress (state != IDLE).

Behaviour:
- Reset: already decided — one clock, clk_i; reset rst_i is synchronous and active-high.
  - Reset forces state=IDLE, txd_o=1, busy_o=0, baud and bit counters to 0, shift register to 0.
  - fifo_ren_o=0 in any cycle with rst_i=1.
- States: IDLE, START, DATA, STOP (PARITY is added by the optional feature).
- Baud counter: counts 0..BAUD_DIV-1 in every non-IDLE state. The tick fires when count=BAUD_DIV-1; the counter then wraps to 0.
- IDLE:
  - fifo_ren_o = enable_i & ~fifo_empty_i & ~rst_i.
  - In the same cycle, the shift register loads fifo_data_i and the state moves to START.
  - Consequence: the pop and the capture of the data are atomic; no separate hold register.
- START: txd_o=0 from the cycle after the pop, held for BAUD_DIV cycles. On tick, go to DATA with bit_cnt=0.
- DATA: txd_o = shift[0]. On tick, shift right by one and increment bit_cnt. When bit_cnt=DATA_WIDTH-1 on tick, go to STOP.
- STOP: txd_o=1 for BAUD_DIV cycles, then IDLE.
- Latency: if fifo_empty_i falls at cycle N (with enable_i=1), fifo_ren_o is high at N and txd_o falls at N+1.
- Frame length: (DATA_WIDTH+2)*BAUD_DIV cycles.
- Back-to-back: the IDLE cycle between frames extends the stop bit to BAUD_DIV+1 cycles. Gaps of one extra cycle or more are legal.
- fifo_ren_o is never asserted outside IDLE and never while fifo_empty_i=1, so no underflow is possible.
- enable_i is sampled only in IDLE. Deasserting it mid-frame has no effect on the current frame.
- rst_i mid-frame: txd_o=1 on the next cycle, the frame is aborted, the character is lost (already popped), and no pop occurs in the reset cycle.
- busy_o is registered and is 1 from the cycle after the pop through the last STOP cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - An extra PARITY state is inserted between DATA and STOP.
  - txd_o = XOR of the loaded character (even parity), held for BAUD_DIV cycles.
  - Parity is computed at load time and kept in a 1-bit register.
  - Frame length becomes (DATA_WIDTH+3)*BAUD_DIV.
- Undefined: no PARITY state and no parity register; the frame is 8N1 as above.

Decomposition:
- Shared UART header/package holds:
  - state encodings (2-bit without parity, 3-bit with it);
  - the default BAUD_DIV constant;
  - the UART_TX_PARITY_EN define, placed alongside the other feature switches.
- One natural sub-module: uart_baud_tick. It contains the DIV_WIDTH-bit counter, has run/clear inputs and a tick output, and is reused later by the RX sampler.

Test Plan:
- Reset, then idle for 20 cycles -> txd_o=1, busy_o=0, fifo_ren_o=0 throughout.
- Reset asserted mid-DATA -> txd_o=1 on the following cycle; busy_o=0; after release, a new non-empty FIFO pops at the next cycle.
- BAUD_DIV=4, enable_i=1, FIFO holds 0xA5, empty falls at cycle 10:
  - fifo_ren_o=1 only at cycle 10.
  - txd_o=0 for cycles 11-14, then bit pattern 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for cycles 47-50.
  - busy_o falls at cycle 51.
- BAUD_DIV=4, FIFO holds 0x00 and 0xFF back-to-back:
  - Exactly two pops, 41 cycles apart.
  - The second start bit begins 5 cycles after the first stop bit begins... [correction: the second start bit follows 4 stop cycles plus the 1 IDLE cycle].
- enable_i=0 with FIFO non-empty -> no pop and txd_o stays 1. Drop enable_i during DATA -> the current frame completes, then no further pop.
- UART_TX_PARITY_EN defined, BAUD_DIV=4, bytes 0xA5 and 0x01 -> parity bit 0 for 0xA5 and 1 for 0x01, each held 4 cycles; frame length 44 cycles.

Source files
------------

// File: rtl/uart_tx_serializer_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer_pkg
//
// Purpose: shared definitions for the UART transmit path. It holds the FSM
// state encoding, the default character width, the default baud divisor and
// the default baud counter width.
//
// Feature switches:
//   UART_TX_PARITY_EN  When defined, the transmitter adds an even-parity bit
//                      between the data bits and the stop bit. This needs a
//                      3-bit state encoding that includes ST_PARITY. When
//                      undefined, frames are plain 8N1 and the encoding is
//                      2 bits.
//
// No ports: this is a package.
// ---------------------------------------------------------------------------
package uart_tx_serializer_pkg;

  // 50 MHz system clock / 115200 baud
  localparam int unsigned DEFAULT_BAUD_DIV   = 434;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_DIV_WIDTH  = 16;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_serializer_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//
// Purpose: baud-rate divider. A DIV_WIDTH-bit counter runs from 0 up to
// BAUD_DIV-1 while run_i is high, then wraps back to 0. The tick output is
// high during the terminal count. The RX sampler shares this block.
//
// Ports:
//   clk_i    in  1  system clock
//   rst_i    in  1  synchronous reset, active-high
//   run_i    in  1  count enable; while low, the counter is held at 0
//   clear_i  in  1  synchronous clear back to 0 (takes priority over run_i)
//   tick_o   out 1  high in the cycle where count = BAUD_DIV-1 while running
// ---------------------------------------------------------------------------
module uart_baud_tick
  import uart_tx_serializer_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = DEFAULT_DIV_WIDTH,
  parameter int unsigned BAUD_DIV  = DEFAULT_BAUD_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [DIV_WIDTH-1:0] TERMINAL = DIV_WIDTH'(BAUD_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  assign tick_o = run_i && (cnt_q == TERMINAL);

  // When the counter is stopped it sits at 0. This way the first tick after
  // the counter is started comes exactly BAUD_DIV cycles later.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !run_i) begin
      cnt_d = '0;
    end else if (cnt_q == TERMINAL) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Purpose: transmit stage of the UART. It pops characters from a
// first-word-fall-through TX FIFO and sends each one as a frame: a start bit,
// then the data bits LSB first, then a stop bit. Each bit lasts BAUD_DIV
// clocks. It also reports when it is busy.
//
// Build option: when UART_TX_PARITY_EN is defined, an even-parity bit is
// added after the data bits.
//
// Ports:
//   clk_i         in  1           system clock, rising edge
//   rst_i         in  1           synchronous reset, active-high
//   enable_i      in  1           allows a new frame to start (sampled only
//                                 in IDLE)
//   fifo_data_i   in  DATA_WIDTH  FIFO head word (valid while not empty)
//   fifo_empty_i  in  1           FIFO empty flag
//   fifo_ren_o    out 1           pop strobe, combinational, one per character
//   txd_o         out 1           serial line, registered, idles high
//   busy_o        out 1           registered, high while a frame is in flight
// ---------------------------------------------------------------------------
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int unsigned DIV_WIDTH  = DEFAULT_DIV_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_ren_o,
  output logic                  txd_o,
  output logic                  busy_o
);

  localparam int unsigned       CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  txd_q, txd_d;
  logic                  busy_q;
  logic                  pop;
  logic                  baud_tick;
  logic                  baud_run;
  logic                  baud_clear;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign baud_run   = (state_q != ST_IDLE);
  assign baud_clear = (state_q == ST_IDLE);

  uart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH),
    .BAUD_DIV  (BAUD_DIV)
  ) u_baud_tick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run_i   (baud_run),
    .clear_i (baud_clear),
    .tick_o  (baud_tick)
  );

  // The pop is gated by reset here, so a reset cycle can never consume a
  // character, even though the FSM is in IDLE.
  assign fifo_ren_o = pop & ~rst_i;
  assign txd_o      = txd_q;
  assign busy_o     = busy_q;

  // The pop and the capture into the shift register happen in the same
  // cycle, so no separate holding register is needed. txd is computed from
  // the next state, which lets the registered output follow the state with
  // no extra cycle of delay.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;
    txd_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (enable_i && !fifo_empty_i) begin
          pop       = 1'b1;
          shift_d   = fifo_data_i;
          bit_cnt_d = '0;
          state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^fifo_data_i;
`endif
        end
      end
      ST_START: begin
        if (baud_tick) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (baud_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      busy_q    <= (state_d != ST_IDLE);
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule
